// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with streaming dump port.
// Optional build macro: REGFILE_WRITE_BYPASS_EN (same-cycle write forwarding).
package regfile_pkg;

    localparam int REG_W    = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump sequencer: walks the index range, raises the load strobe and runs the valid/ready handshake.
// Handshake: a beat transfers on a rising edge where dump_valid & dump_ready; valid holds until then.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W    = REG_AW,
    parameter int DUMP_FROM = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] rd_idx,
    output logic              load_en,
    output logic              dump_valid,
    output logic              dump_busy,
    output dump_state_t       state
);

    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(2**ADDR_W - 1);
    localparam logic [ADDR_W:0] FIRST_IDX = (ADDR_W+1)'(DUMP_FROM);

    dump_state_t     state_nxt;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load_en   = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = LOAD;
                    idx_nxt   = FIRST_IDX;
                end
            end
            LOAD: begin
                load_en   = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                // The last index retires to DONE, so idx never steps past it.
                if (dump_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Valid derives from state so that an asynchronous reset drops it at once.
    assign dump_valid = (state == SEND);
    assign dump_busy  = (state != IDLE);
    assign rd_idx     = idx[ADDR_W-1:0];

endmodule

// File: rtl/regfile_dump.sv
// 2-read/1-write register file with r0 hardwired to zero and a valid/ready dump stream.
// Optional build macro: REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to reads and dump capture.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int DATA_W    = REG_W,
    parameter int ADDR_W    = REG_AW,
    parameter int DUMP_FROM = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              dump_busy,
    output dump_state_t       dump_state
);

    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_fire;
    logic [ADDR_W-1:0] load_idx;
    logic              load_en;
    logic [DATA_W-1:0] load_val;

    assign wr_fire = ctrl_writeEnable && (ctrl_writeReg != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_fire) begin
            mem[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Read ports plus the dump capture port share one lookup rule: r0 is zero, bypass optional.
    always_comb begin
        data_readRegA = mem[ctrl_readRegA];
        data_readRegB = mem[ctrl_readRegB];
        load_val      = mem[load_idx];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_fire && (ctrl_writeReg == ctrl_readRegA)) data_readRegA = data_writeReg;
        if (wr_fire && (ctrl_writeReg == ctrl_readRegB)) data_readRegB = data_writeReg;
        if (wr_fire && (ctrl_writeReg == load_idx))      load_val      = data_writeReg;
`endif
        if (ctrl_readRegA == '0) data_readRegA = '0;
        if (ctrl_readRegB == '0) data_readRegB = '0;
        if (load_idx == '0)      load_val      = '0;
    end

    regfile_dump_fsm #(
        .ADDR_W    (ADDR_W),
        .DUMP_FROM (DUMP_FROM)
    ) u_fsm (
        .clock      (clock),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .rd_idx     (load_idx),
        .load_en    (load_en),
        .dump_valid (dump_valid),
        .dump_busy  (dump_busy),
        .state      (dump_state)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dump_idx  <= '0;
            dump_data <= '0;
        end else if (load_en) begin
            dump_idx  <= load_idx;
            dump_data <= load_val;
        end
    end

    assign dump_last = dump_valid && (dump_idx == LAST_IDX);

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: reads/writes, r0 protection, bypass, dump streaming,
// backpressure and reset abort, with a scoreboard queue for dump beats.
module tb_regfile_dump;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] ctrl_readRegA;
    logic [AW-1:0] ctrl_readRegB;
    logic [DW-1:0] data_readRegA;
    logic [DW-1:0] data_readRegB;
    logic          dump_start;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          dump_last;
    logic          dump_busy;
    dump_state_t   dump_state;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    model [32];
    int               checks = 0;
    int               errors = 0;

    regfile_dump dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .dump_start       (dump_start),
        .dump_valid       (dump_valid),
        .dump_ready       (dump_ready),
        .dump_idx         (dump_idx),
        .dump_data        (dump_data),
        .dump_last        (dump_last),
        .dump_busy        (dump_busy),
        .dump_state       (dump_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks: each starts and ends on a falling edge
    task automatic write_reg(input int idx, input logic [DW-1:0] val);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = AW'(idx);
        data_writeReg    = val;
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        if (idx != 0) model[idx] = val;
    endtask

    task automatic run_dump(input int stall_at, input int stall_len, input bit poke);
        int stall_left;
        int cyc;
        logic [AW+DW-1:0] e;
        stall_left = stall_len;
        cyc = 0;
        for (int i = 0; i < 32; i++) exp_q.push_back({AW'(i), model[i]});
        dump_ready = 1'b1;
        dump_start = 1'b1;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(negedge clock);
            cyc++;
            dump_start = 1'b0;
            if (dump_valid) begin
                e = exp_q[0];
                if (stall_left > 0 && int'(dump_idx) == stall_at) begin
                    check("hold_idx", 64'(dump_idx), 64'(e[AW+DW-1:DW]));
                    check("hold_data", 64'(dump_data), 64'(e[DW-1:0]));
                    dump_ready = 1'b0;
                    stall_left--;
                    if (poke && stall_left == 2) dump_start = 1'b1;
                end else begin
                    dump_ready = 1'b1;
                    e = exp_q.pop_front();
                    check("beat_idx", 64'(dump_idx), 64'(e[AW+DW-1:DW]));
                    check("beat_data", 64'(dump_data), 64'(e[DW-1:0]));
                    check("beat_last", 64'(dump_last), 64'(e[AW+DW-1:DW] == 5'd31));
                end
            end
        end
        check("dump_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clock);
        check("done_valid", 64'(dump_valid), 64'd0);
        check("done_busy", 64'(dump_busy), 64'd1);
        @(negedge clock);
        check("idle_busy", 64'(dump_busy), 64'd0);
        @(negedge clock);
        check("no_restart", 64'(dump_busy), 64'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg = '0;
        data_writeReg = '0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_valid", 64'(dump_valid), 64'd0);
        check("rst_busy", 64'(dump_busy), 64'd0);
        check("rst_last", 64'(dump_last), 64'd0);
        check("rst_idx", 64'(dump_idx), 64'd0);
        check("rst_data", 64'(dump_data), 64'd0);
        check("rst_state", 64'(dump_state), 64'(IDLE));
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = AW'(i);
            ctrl_readRegB = AW'(31 - i);
            #1;
            check("rst_readA", 64'(data_readRegA), 64'd0);
            check("rst_readB", 64'(data_readRegB), 64'd0);
        end
        @(negedge clock);

        write_reg(5, 32'hDEADBEEF);
        ctrl_readRegA = 5'd5;
        #1 check("readA_r5", 64'(data_readRegA), 64'hDEADBEEF);

        write_reg(0, 32'h12345678);
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        #1;
        check("r0_readA", 64'(data_readRegA), 64'd0);
        check("r0_readB", 64'(data_readRegB), 64'd0);
        write_reg(1, 32'd2);
        ctrl_readRegB = 5'd1;
        #1 check("readB_r1", 64'(data_readRegB), 64'd2);

        // same-cycle write and read of r7
        @(negedge clock);
        ctrl_readRegA = 5'd7;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg = 5'd7;
        data_writeReg = 32'hA5;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("bypass_same", 64'(data_readRegA), 64'hA5);
`else
        check("bypass_same", 64'(data_readRegA), 64'd0);
`endif
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        model[7] = 32'hA5;
        #1 check("bypass_next", 64'(data_readRegA), 64'hA5);

        for (int i = 1; i < 32; i++) write_reg(i, DW'(i * 3));
        run_dump(-1, 0, 1'b0);

        for (int i = 1; i < 32; i += 2) write_reg(i, DW'($urandom_range(32'h7fff_ffff, 0)));
        run_dump(9, 5, 1'b1);

        // abort a dump with reset at index 12
        for (int i = 1; i < 32; i++) write_reg(i, DW'(i * 3));
        dump_ready = 1'b1;
        dump_start = 1'b1;
        cyc = 0;
        while (!(dump_valid && dump_idx == 5'd12) && cyc < 200) begin
            @(negedge clock);
            dump_start = 1'b0;
            cyc++;
        end
        check("reach_idx12", 64'(cyc < 200), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_valid", 64'(dump_valid), 64'd0);
        check("abort_busy", 64'(dump_busy), 64'd0);
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = AW'(i);
            #1 check("abort_reg", 64'(data_readRegA), 64'd0);
            model[i] = '0;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_dump(-1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
